pipe_stage_skid: RTL

//  Parametrised pipeline stage register for the five-stage MIPS core; replaces the fixed per-stage latches.

---
 rtl/pipe_stage_skid.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer so in_ready comes straight from a flop.
// Carries instr/pc/wreg/data/tnew; supports flush (bubble insert) and optional Tnew decrement.
module pipe_stage_skid #(
  parameter int          DATA_W   = 64,
  parameter int          TNEW_W   = 2,
  parameter bit          DEC_TNEW = 1'b1,
  parameter logic [31:0] PC_RESET = 32'h3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_wreg,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_wreg,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // in_ready is decoded from the state register only, never from out_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [4:0]        wreg;
    logic [DATA_W-1:0] data;
    logic [TNEW_W-1:0] tnew;
  } entry_t;

  state_t state, state_nx;
  entry_t main_q, skid_q, cap;
  logic   acc, pop;
  logic   load_main, load_skid, shift;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_comb begin
    cap       = '0;
    cap.instr = in_instr;
    cap.pc    = in_pc;
    cap.wreg  = in_wreg;
    cap.data  = in_data;
    if (DEC_TNEW) begin
      cap.tnew = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
    end else begin
      cap.tnew = in_tnew;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (acc) state_nx = ONE;
        ONE: begin
          if (acc && !pop)      state_nx = FULL;
          else if (!acc && pop) state_nx = EMPTY;
        end
        FULL:    if (pop) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    dbg_state = state;
    out_pc    = main_q.pc;
    out_data  = main_q.data;
    out_instr = out_valid ? main_q.instr : '0;
    out_wreg  = out_valid ? main_q.wreg  : '0;
    out_tnew  = out_valid ? main_q.tnew  : '0;
  end

  assign load_main = acc & ((state == EMPTY) | ((state == ONE) & pop));
  assign load_skid = acc & (state == ONE) & ~pop;
  assign shift     = (state == FULL) & pop;

  // Entries only change on capture, shift or flush; held entries stay stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '{instr: '0, pc: PC_RESET, wreg: '0, data: '0, tnew: '0};
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '{instr: '0, pc: PC_RESET, wreg: '0, data: '0, tnew: '0};
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= cap;
      end else if (shift) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= cap;
      end
    end
  end

endmodule
